// File: rtl/coef_sequencer.sv
// Coefficient ROM fetch controller: walks one bank per start request and streams the
// coefficients over valid/ready, hiding the one-cycle ROM latency in a 2-entry buffer.
module coef_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned TAPS       = 32,
  parameter int unsigned NUM_BANKS  = 1,
  parameter int unsigned BANK_WIDTH = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  parameter int unsigned TAP_WIDTH  = $clog2(TAPS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_valid_i,
  output logic                  start_ready_o,
  input  logic [BANK_WIDTH-1:0] coef_bank_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [DATA_WIDTH-1:0] coef_o,
  output logic [TAP_WIDTH-1:0]  tap_o,
  output logic                  coef_last_o,
  output logic                  coef_valid_o,
  input  logic                  coef_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e r_state;
  state_e w_state_next;

  logic [ADDR_WIDTH-1:0] r_base;
  logic [TAP_WIDTH-1:0]  r_tap_cnt;
  logic                  r_inflight;
  logic [TAP_WIDTH-1:0]  r_inflight_tap;
  logic [DATA_WIDTH-1:0] r_buf_data [2];
  logic [TAP_WIDTH-1:0]  r_buf_tap  [2];
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_count;
  logic                  r_done;
  logic                  r_err;

  logic                  w_start_ready;
  logic                  w_accept;
  logic [31:0]           w_bank_ext;
  logic                  w_bank_bad;
  logic [31:0]           w_base_full;
  logic                  w_valid;
  logic [TAP_WIDTH-1:0]  w_head_tap;
  logic                  w_pop;
  logic                  w_last_pop;
  logic [2:0]            w_occ;
  logic                  w_issue;
  logic                  w_last_issue;

  assign w_start_ready = (r_state == StIdle) && !rst_i;
  assign w_accept      = start_valid_i && w_start_ready;

  // Out-of-range banks fall back to bank 0.
  assign w_bank_ext  = 32'(coef_bank_i);
  assign w_bank_bad  = (w_bank_ext >= NUM_BANKS);
  assign w_base_full = (w_bank_bad ? 32'd0 : w_bank_ext) * TAPS;

  assign w_valid    = (r_count != 2'd0);
  assign w_head_tap = r_buf_tap[r_rd_ptr];
  assign w_pop      = w_valid && coef_ready_i;
  assign w_last_pop = w_pop && (w_head_tap == TAP_WIDTH'(TAPS - 1));

  // Issue only if the read can land in the buffer after this cycle's pop.
  assign w_occ        = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_issue      = (r_state == StRun) && (w_occ < (3'd2 + {2'b00, w_pop}));
  assign w_last_issue = w_issue && (r_tap_cnt == TAP_WIDTH'(TAPS - 1));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept)     w_state_next = StRun;
      StRun:   if (w_last_issue) w_state_next = StDrain;
      StDrain: if (w_last_pop)   w_state_next = StIdle;
      default:                   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_base         <= '0;
      r_tap_cnt      <= '0;
      r_inflight     <= 1'b0;
      r_inflight_tap <= '0;
      r_buf_data[0]  <= '0;
      r_buf_data[1]  <= '0;
      r_buf_tap[0]   <= '0;
      r_buf_tap[1]   <= '0;
      r_rd_ptr       <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_count        <= 2'd0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_done <= w_last_pop;
      r_err  <= w_accept && w_bank_bad;

      // The counter parks on the final tap so the address stays inside the bank.
      if (w_accept) begin
        r_base    <= w_base_full[ADDR_WIDTH-1:0];
        r_tap_cnt <= '0;
      end else if (w_issue && !w_last_issue) begin
        r_tap_cnt <= r_tap_cnt + TAP_WIDTH'(1);
      end

      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_tap <= r_tap_cnt;
      end

      if (r_inflight) begin
        r_buf_data[r_wr_ptr] <= rom_data_i;
        r_buf_tap[r_wr_ptr]  <= r_inflight_tap;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + 2'(r_inflight) - 2'(w_pop);
    end
  end

  assign start_ready_o = w_start_ready;
  assign rom_addr_o    = (r_state == StIdle) ? '0 : r_base + ADDR_WIDTH'(r_tap_cnt);
  assign coef_o        = r_buf_data[r_rd_ptr];
  assign tap_o         = w_head_tap;
  assign coef_last_o   = w_valid && (w_head_tap == TAP_WIDTH'(TAPS - 1));
  assign coef_valid_o  = w_valid;
  assign busy_o        = (r_state != StIdle);
  assign done_o        = r_done;
  assign err_o         = r_err;

endmodule
